// File: rtl/beeb_bus_pkg.sv
// Shared types and default parameters for the Phi0-retimed host bus bridge.
package beeb_bus_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 3;
  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned STRETCH_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CYCLE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/beeb_bus_if.sv
// CPU req/ack handshake plus host socket bus signals; slave = bridge side.
interface beeb_bus_if #(
  parameter int unsigned ADDR_W = beeb_bus_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = beeb_bus_pkg::DATA_W_DEF
);
  logic              req;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              ack;
  logic [DATA_W-1:0] ack_rdata;

  logic [ADDR_W-1:0] bus_addr;
  logic              bus_rnw;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_data_oe;
  logic [DATA_W-1:0] bus_data_i;

  modport master (
    output req, req_we, req_addr, req_wdata, bus_data_i,
    input  ack, ack_rdata, bus_addr, bus_rnw, bus_data_o, bus_data_oe
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, bus_data_i,
    output ack, ack_rdata, bus_addr, bus_rnw, bus_data_o, bus_data_oe
  );
endinterface

// File: rtl/beeb_phi_sync.sv
// Phi0/RDY/data synchronisers and Phi0 edge pulses. Data is delayed one stage
// beyond Phi0 so data_s is the last sample taken while Phi0 was still high.
module beeb_phi_sync #(
  parameter int unsigned SYNC_STAGES = beeb_bus_pkg::SYNC_STAGES_DEF,
  parameter int unsigned DATA_W      = beeb_bus_pkg::DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              phi_in,
  input  logic              rdy_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ps,
  output logic              ps_n,
  output logic              ps_nxt,
  output logic              rdy_s,
  output logic [DATA_W-1:0] data_s,
  output logic              fall_c,
  output logic              rise_c
);

  logic [SYNC_STAGES-1:0] phi_sr;
  logic [SYNC_STAGES-1:0] rdy_sr;
  logic                   ps_prev;
  logic [DATA_W-1:0]      data_sr [SYNC_STAGES+1];

  always_ff @(posedge clock) begin
    if (reset) begin
      phi_sr  <= '0;
      rdy_sr  <= '0;
      ps_prev <= 1'b0;
      ps_n    <= 1'b1;
      for (int i = 0; i <= int'(SYNC_STAGES); i++) data_sr[i] <= '0;
    end else begin
      phi_sr  <= {phi_sr[SYNC_STAGES-2:0], phi_in};
      rdy_sr  <= {rdy_sr[SYNC_STAGES-2:0], rdy_in};
      ps_prev <= phi_sr[SYNC_STAGES-1];
      // Inverted copy tracks the final stage so phi1_out is itself a flop
      ps_n    <= ~phi_sr[SYNC_STAGES-2];
      data_sr[0] <= data_in;
      for (int i = 1; i <= int'(SYNC_STAGES); i++) data_sr[i] <= data_sr[i-1];
    end
  end

  assign ps     = phi_sr[SYNC_STAGES-1];
  assign ps_nxt = phi_sr[SYNC_STAGES-2];
  assign rdy_s  = rdy_sr[SYNC_STAGES-1];
  assign data_s = data_sr[SYNC_STAGES];
  assign fall_c = ps_prev & ~ps;
  assign rise_c = ~ps_prev & ps;

endmodule

// File: rtl/beeb_bus_bridge.sv
// Runs one host bus cycle per Phi0 period for the soft CPU, honouring RDY.
// Define BEEB_BUS_POSTED_WRITE_EN to ack writes at acceptance (one-entry post).
module beeb_bus_bridge
  import beeb_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned STRETCH_W   = STRETCH_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 phi_in,
  input  logic                 rdy_in,
  output logic                 phi1_out,
  output logic                 phi2_out,
  output logic [STRETCH_W-1:0] stretch_count,
  beeb_bus_if.slave            bus
);

`ifdef BEEB_BUS_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  bus_state_e state_q, state_d;

  logic              ps_nxt, rdy_s, fall_c, rise_unused_c;
  logic [DATA_W-1:0] data_s;

  logic [ADDR_W-1:0]    lat_addr_q, lat_addr_d;
  logic                 lat_we_q, lat_we_d;
  logic [DATA_W-1:0]    lat_wdata_q, lat_wdata_d;
  logic                 posted_q, posted_d;
  logic                 done_q, done_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 rnw_q, rnw_d;
  logic [DATA_W-1:0]    data_o_q, data_o_d;
  logic                 oe_q, oe_d;
  logic                 ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [STRETCH_W-1:0] stretch_q, stretch_d;

  beeb_phi_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .DATA_W     (DATA_W)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .phi_in (phi_in),
    .rdy_in (rdy_in),
    .data_in(bus.bus_data_i),
    .ps     (phi2_out),
    .ps_n   (phi1_out),
    .ps_nxt (ps_nxt),
    .rdy_s  (rdy_s),
    .data_s (data_s),
    .fall_c (fall_c),
    .rise_c (rise_unused_c)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // done_q marks the clock after completion, where a held req chains straight on
  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_we_d    = lat_we_q;
    lat_wdata_d = lat_wdata_q;
    posted_d    = posted_q;
    done_d      = done_q;
    addr_d      = addr_q;
    rnw_d       = rnw_q;
    data_o_d    = data_o_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    stretch_d   = stretch_q;

    case (state_q)
      IDLE: begin
        rnw_d = 1'b1;
        if (bus.req) begin
          lat_addr_d  = bus.req_addr;
          lat_we_d    = bus.req_we;
          lat_wdata_d = bus.req_wdata;
          posted_d    = POSTED && bus.req_we;
          ack_d       = POSTED && bus.req_we;
          state_d     = ARMED;
        end
      end
      ARMED: begin
        if (fall_c) begin
          addr_d  = lat_addr_q;
          rnw_d   = ~lat_we_q;
          if (lat_we_q) data_o_d = lat_wdata_q;
          state_d = CYCLE;
        end
      end
      CYCLE: begin
        if (done_q) begin
          done_d = 1'b0;
          if (bus.req) begin
            lat_addr_d  = bus.req_addr;
            lat_we_d    = bus.req_we;
            lat_wdata_d = bus.req_wdata;
            posted_d    = POSTED && bus.req_we;
            ack_d       = POSTED && bus.req_we;
            addr_d      = bus.req_addr;
            rnw_d       = ~bus.req_we;
            if (bus.req_we) data_o_d = bus.req_wdata;
          end else begin
            rnw_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (fall_c) begin
          if (rdy_s) begin
            done_d   = 1'b1;
            posted_d = 1'b0;
            if (!posted_q) begin
              ack_d = 1'b1;
              if (!lat_we_q) rdata_d = data_s;
            end
          end else if (!(&stretch_q)) begin
            stretch_d = stretch_q + STRETCH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next Phi0 level so oe tracks phi2_out exactly
    oe_d = (state_d == CYCLE) && lat_we_d && ps_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
      posted_q    <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      rnw_q       <= 1'b1;
      data_o_q    <= '0;
      oe_q        <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      stretch_q   <= '0;
    end else begin
      lat_addr_q  <= lat_addr_d;
      lat_we_q    <= lat_we_d;
      lat_wdata_q <= lat_wdata_d;
      posted_q    <= posted_d;
      done_q      <= done_d;
      addr_q      <= addr_d;
      rnw_q       <= rnw_d;
      data_o_q    <= data_o_d;
      oe_q        <= oe_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      stretch_q   <= stretch_d;
    end
  end

  assign bus.bus_addr    = addr_q;
  assign bus.bus_rnw     = rnw_q;
  assign bus.bus_data_o  = data_o_q;
  assign bus.bus_data_oe = oe_q;
  assign bus.ack         = ack_q;
  assign bus.ack_rdata   = rdata_q;
  assign stretch_count   = stretch_q;

endmodule

// File: tb/tb_beeb_bus_bridge.sv
// Randomised bench for beeb_bus_bridge against a host-memory reference model.
module tb_beeb_bus_bridge;

  localparam int unsigned S    = 3;
  localparam int          HALF = 16;
  localparam int          PER  = 2 * HALF;
`ifdef BEEB_BUS_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       phi_in;
  logic       rdy_in;
  logic       phi1_out;
  logic       phi2_out;
  logic [7:0] stretch_count;

  beeb_bus_if #(.ADDR_W(16), .DATA_W(8)) bif ();

  beeb_bus_bridge #(
    .SYNC_STAGES(S),
    .ADDR_W     (16),
    .DATA_W     (8),
    .STRETCH_W  (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .phi_in       (phi_in),
    .rdy_in       (rdy_in),
    .phi1_out     (phi1_out),
    .phi2_out     (phi2_out),
    .stretch_count(stretch_count),
    .bus          (bif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  host_mem [65536];
  logic [7:0]  ref_mem  [65536];
  logic [15:0] wlog_addr [$];
  logic [7:0]  wlog_data [$];
  int raw_rises = 0;
  int fall_cnt  = 0;
  int ack_cnt   = 0;
  int oe_viol   = 0;
  int rnw_err   = 0;
  int exp_stretch = 0;
  logic p2_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input int i);
    if (i == 32'hFE40) return 8'h5A;
    return 8'((i * 73) ^ (i >>> 5));
  endfunction

  // Host socket: 6502-style Phi0, data driven in high phase, writes strobed at Phi0 fall
  initial begin
    phi_in = 1'b0;
    bif.bus_data_i = '0;
    for (int i = 0; i < 65536; i++) host_mem[i] = init_val(i);
    forever begin
      repeat (HALF) @(posedge clock);
      #1;
      if (!phi_in) begin
        phi_in = 1'b1;
        raw_rises++;
        bif.bus_data_i = bif.bus_rnw ? host_mem[bif.bus_addr] : 8'($urandom);
      end else begin
        if (bif.bus_data_oe && !bif.bus_rnw) begin
          host_mem[bif.bus_addr] = bif.bus_data_o;
          wlog_addr.push_back(bif.bus_addr);
          wlog_data.push_back(bif.bus_data_o);
        end
        phi_in = 1'b0;
        bif.bus_data_i = 8'($urandom);
      end
    end
  end

  always @(negedge clock) begin
    if (p2_prev && !phi2_out) fall_cnt++;
    p2_prev = phi2_out;
    if (bif.ack) ack_cnt++;
    if (bif.bus_data_oe && (!phi2_out || bif.bus_rnw)) oe_viol++;
  end

  task automatic wait_ack(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (bif.ack) ok = 1'b1;
    end
  endtask

  // One request issued just after a raw Phi0 rise, with s RDY-stretched periods
  task automatic xfer(input logic we, input logic [15:0] addr, input logic [7:0] wd, input int s);
    int f0, a0, w0, r0, n, budget, oe_hi;
    bit got_ack, done, posted_w;
    posted_w = POSTED && we;
    @(posedge phi_in);
    @(negedge clock);
    rdy_in = (s == 0);
    f0 = fall_cnt; a0 = ack_cnt; w0 = wlog_addr.size(); r0 = raw_rises;
    bif.req = 1'b1; bif.req_we = we; bif.req_addr = addr; bif.req_wdata = wd;
    if (we) ref_mem[addr] = wd;
    budget = (s + 4) * PER + 64;
    n = 0; oe_hi = 0; got_ack = 1'b0; done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clock);
      n++;
      if (raw_rises - r0 >= s + 1) rdy_in = 1'b1;
      if (!we && !bif.bus_rnw) rnw_err++;
      if (bif.bus_data_oe) oe_hi++;
      if (bif.ack && !got_ack) begin
        got_ack = 1'b1;
        bif.req = 1'b0;
        if (posted_w) check("posted_ack_lat", n, 1);
        else begin
          check("ack_falls", fall_cnt - f0, s + 2);
          check("ack_addr", bif.bus_addr, addr);
        end
        if (!we) check("rdata", bif.ack_rdata, ref_mem[addr]);
      end
      done = got_ack && (fall_cnt - f0 >= s + 2);
    end
    check("xfer_done", done, 1);
    bif.req = 1'b0;
    rdy_in = 1'b1;
    repeat (4) @(negedge clock);
    check("ack_once", ack_cnt - a0, 1);
    check("wlog_n", wlog_addr.size() - w0, we ? s + 1 : 0);
    check("oe_seen", oe_hi > 0, we);
    if (we && wlog_addr.size() > w0) begin
      check("wr_addr", wlog_addr[$], addr);
      check("wr_data", wlog_data[$], wd);
    end
    exp_stretch = (exp_stretch + s > 255) ? 255 : exp_stretch + s;
    check("stretch", stretch_count, exp_stretch);
  endtask

  task automatic check_reset_outputs();
    check("rst_phi1", phi1_out, 1);
    check("rst_phi2", phi2_out, 0);
    check("rst_addr", bif.bus_addr, 0);
    check("rst_rnw", bif.bus_rnw, 1);
    check("rst_data_o", bif.bus_data_o, 0);
    check("rst_oe", bif.bus_data_oe, 0);
    check("rst_ack", bif.ack, 0);
    check("rst_rdata", bif.ack_rdata, 0);
    check("rst_stretch", stretch_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, f1, a0, w0;
    bit ok;
    logic [15:0] ra;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
    reset = 1'b1; rdy_in = 1'b1;
    bif.req = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    repeat (5) @(negedge clock);
    check_reset_outputs();
    reset = 1'b0;
    repeat (3 * PER) @(negedge clock);

    xfer(1'b0, 16'hFE40, 8'h00, 0);
    check("rd_fe40", bif.ack_rdata, 8'h5A);
    xfer(1'b1, 16'h3000, 8'hA5, 0);
    check("wr_3000", host_mem[16'h3000], 8'hA5);
    xfer(1'b0, 16'h3000, 8'h00, 0);
    xfer(1'b0, 16'h2345, 8'h00, 2);

    // Back-to-back reads with req held across the first ack
    @(posedge phi_in);
    @(negedge clock);
    f0 = fall_cnt; a0 = ack_cnt;
    bif.req = 1'b1; bif.req_we = 1'b0; bif.req_addr = 16'h1000;
    wait_ack(4 * PER, ok);
    check("b2b_ack0", ok, 1);
    check("b2b_falls0", fall_cnt - f0, 2);
    check("b2b_rdata0", bif.ack_rdata, ref_mem[16'h1000]);
    f1 = fall_cnt;
    bif.req_addr = 16'h1001;
    wait_ack(4 * PER, ok);
    bif.req = 1'b0;
    check("b2b_ack1", ok, 1);
    check("b2b_falls1", fall_cnt - f1, 1);
    check("b2b_addr1", bif.bus_addr, 16'h1001);
    check("b2b_rdata1", bif.ack_rdata, ref_mem[16'h1001]);
    repeat (4) @(negedge clock);
    check("b2b_acks", ack_cnt - a0, 2);

    for (int k = 0; k < 16; k++)
      xfer(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), $urandom_range(0, 2));

    // Reset while a write is driving the bus
    @(posedge phi_in);
    @(negedge clock);
    w0 = wlog_addr.size();
    ra = 16'($urandom);
    bif.req = 1'b1; bif.req_we = 1'b1; bif.req_addr = ra; bif.req_wdata = 8'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 3 * PER && !ok; i++) begin
      @(negedge clock);
      if (bif.bus_data_oe) ok = 1'b1;
    end
    check("rst_oe_seen", ok, 1);
    a0 = ack_cnt;
    reset = 1'b1; bif.req = 1'b0;
    @(negedge clock);
    check_reset_outputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_stretch = 0;
    repeat (3 * PER) @(negedge clock);
    check("rst_no_ack", ack_cnt - a0, 0);
    check("rst_no_write", wlog_addr.size() - w0, 0);

    // Saturate the stretch counter, then stretch once more
    xfer(1'b0, 16'h0042, 8'h00, 260);
    check("sat_ff", stretch_count, 8'hFF);
    xfer(1'b0, 16'h0043, 8'h00, 1);
    check("sat_hold", stretch_count, 8'hFF);

    check("oe_phase", oe_viol, 0);
    check("read_rnw", rnw_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
